// File: rtl/global_buffer_param.sv
// Global buffer sizing constants shared by every glb_* block.
package global_buffer_param;

    localparam int GLB_ADDR_WIDTH  = 19;
    localparam int BANK_DATA_WIDTH = 64;
    localparam int LATENCY_WIDTH   = 4;

endpackage

// File: rtl/global_buffer_pkg.sv
// Global buffer types and defaults: read requester ids, tag layout, latency clamp.
package global_buffer_pkg;

    import global_buffer_param::*;

    localparam int GLB_MAX_LATENCY = 8;

    // Tag carried down the delay line: bit 1 = valid, bit 0 = requester id.
    localparam int TAG_WIDTH = 2;

    typedef enum logic {
        RD_ST = 1'b0,
        RD_PC = 1'b1
    } rd_id_e;

    // A zero latency is meaningless for a registered bank, so it maps to 1.
    function automatic logic [LATENCY_WIDTH-1:0] clamp_latency(
        input logic [LATENCY_WIDTH-1:0] raw,
        input logic [LATENCY_WIDTH-1:0] max_lat
    );
        if (raw == '0) begin
            return LATENCY_WIDTH'(1);
        end
        if (raw > max_lat) begin
            return max_lat;
        end
        return raw;
    endfunction

endpackage

// File: rtl/glb_shift.sv
// Fixed-depth shift line with every stage exposed; taps[0] is the newest entry.
module glb_shift #(
    parameter int DATA_WIDTH = 2,
    parameter int DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clk_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic [DEPTH*DATA_WIDTH-1:0] taps
);

    logic [DATA_WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else if (clk_en) begin
            r_stage[0] <= data_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign taps[g*DATA_WIDTH +: DATA_WIDTH] = r_stage[g];
    end

endmodule

// File: rtl/glb_core_rd_arbiter.sv
// Arbitrates stream-DMA and PC-DMA reads onto one bank port and routes the
// returning data back to whichever requester issued it.
module glb_core_rd_arbiter
    import global_buffer_param::*;
    import global_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH  = GLB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = BANK_DATA_WIDTH,
    parameter int MAX_LATENCY = GLB_MAX_LATENCY
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     st_rd_en,
    input  logic [ADDR_WIDTH-1:0]    st_rd_addr,
    output logic                     st_rd_gnt,

    input  logic                     pc_rd_en,
    input  logic [ADDR_WIDTH-1:0]    pc_rd_addr,
    output logic                     pc_rd_gnt,

    output logic                     bank_rd_en,
    output logic [ADDR_WIDTH-1:0]    bank_rd_addr,
    input  logic [DATA_WIDTH-1:0]    bank_rd_data,

    output logic [DATA_WIDTH-1:0]    st_rd_data,
    output logic                     st_rd_data_valid,
    output logic [DATA_WIDTH-1:0]    pc_rd_data,
    output logic                     pc_rd_data_valid,

    input  logic                     cfg_arb_mode,
    input  logic [LATENCY_WIDTH-1:0] cfg_rd_latency,
    output logic                     arb_busy
);

    logic                           w_st_req;
    logic                           w_pc_req;
    logic                           w_st_gnt;
    logic                           w_pc_gnt;
    rd_id_e                         r_last_gnt;
    logic                           r_bank_en;
    logic [ADDR_WIDTH-1:0]          r_bank_addr;
    rd_id_e                         r_issue_id;
    logic [TAG_WIDTH-1:0]           w_tag_in;
    logic [MAX_LATENCY*TAG_WIDTH-1:0] w_taps;
    logic [LATENCY_WIDTH-1:0]       w_lat;
    logic [TAG_WIDTH-1:0]           w_tag;
    rd_id_e                         w_tag_id;
    logic                           w_busy_tags;
    logic                           w_st_hit;
    logic                           w_pc_hit;

    // Requests are masked by reset so no grant can leak out while reset_n is low.
    assign w_st_req = st_rd_en & reset_n;
    assign w_pc_req = pc_rd_en & reset_n;

    always_comb begin
        w_st_gnt = 1'b0;
        w_pc_gnt = 1'b0;
        if (w_st_req && w_pc_req) begin
            if (cfg_arb_mode || (r_last_gnt == RD_ST)) begin
                w_pc_gnt = 1'b1;
            end else begin
                w_st_gnt = 1'b1;
            end
        end else begin
            w_st_gnt = w_st_req;
            w_pc_gnt = w_pc_req;
        end
    end

    assign st_rd_gnt = w_st_gnt;
    assign pc_rd_gnt = w_pc_gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_gnt  <= RD_PC;
            r_bank_en   <= 1'b0;
            r_bank_addr <= '0;
            r_issue_id  <= RD_ST;
        end else begin
            r_bank_en   <= w_st_gnt | w_pc_gnt;
            r_issue_id  <= w_pc_gnt ? RD_PC : RD_ST;
            if (w_pc_gnt) begin
                r_bank_addr <= pc_rd_addr;
                r_last_gnt  <= RD_PC;
            end else if (w_st_gnt) begin
                r_bank_addr <= st_rd_addr;
                r_last_gnt  <= RD_ST;
            end else begin
                r_bank_addr <= '0;
            end
        end
    end

    assign bank_rd_en   = r_bank_en;
    assign bank_rd_addr = r_bank_addr;

    // The tag enters the line one cycle after issue, so tap L-1 lines up with
    // the data the bank returns L cycles after bank_rd_en.
    assign w_tag_in = {r_bank_en, r_issue_id};

    glb_shift #(
        .DATA_WIDTH (TAG_WIDTH),
        .DEPTH      (MAX_LATENCY)
    ) u_tag_line (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (1'b1),
        .data_in (w_tag_in),
        .taps    (w_taps)
    );

    assign w_lat = clamp_latency(cfg_rd_latency, LATENCY_WIDTH'(MAX_LATENCY));

    // Tags past the return tap have already been answered and do not count as busy.
    always_comb begin
        w_tag       = '0;
        w_busy_tags = 1'b0;
        for (int k = 0; k < MAX_LATENCY; k++) begin
            if (LATENCY_WIDTH'(k + 1) == w_lat) begin
                w_tag = w_taps[k*TAG_WIDTH +: TAG_WIDTH];
            end
            if (LATENCY_WIDTH'(k + 1) <= w_lat) begin
                w_busy_tags = w_busy_tags | w_taps[k*TAG_WIDTH + 1];
            end
        end
    end

    assign w_tag_id = rd_id_e'(w_tag[0]);
    assign w_st_hit = w_tag[1] & (w_tag_id == RD_ST);
    assign w_pc_hit = w_tag[1] & (w_tag_id == RD_PC);

    assign st_rd_data_valid = w_st_hit;
    assign pc_rd_data_valid = w_pc_hit;
    assign st_rd_data       = w_st_hit ? bank_rd_data : '0;
    assign pc_rd_data       = w_pc_hit ? bank_rd_data : '0;

    assign arb_busy = r_bank_en | w_busy_tags;

endmodule

// File: tb/tb_glb_core_rd_arbiter.sv
// Directed bench for glb_core_rd_arbiter: the driver checks grants and issue,
// a bank model returns data, and a monitor scores responses against exp_q.
module tb_glb_core_rd_arbiter;

    import global_buffer_param::*;
    import global_buffer_pkg::*;

    localparam int AW = GLB_ADDR_WIDTH;
    localparam int DW = BANK_DATA_WIDTH;
    localparam int LW = LATENCY_WIDTH;
    // Expected-response entry: {pc_id, data, response_cycle}
    localparam int EW = 1 + DW + 32;

    logic          clk;
    logic          reset_n;
    logic          st_rd_en;
    logic [AW-1:0] st_rd_addr;
    logic          st_rd_gnt;
    logic          pc_rd_en;
    logic [AW-1:0] pc_rd_addr;
    logic          pc_rd_gnt;
    logic          bank_rd_en;
    logic [AW-1:0] bank_rd_addr;
    logic [DW-1:0] bank_rd_data;
    logic [DW-1:0] st_rd_data;
    logic          st_rd_data_valid;
    logic [DW-1:0] pc_rd_data;
    logic          pc_rd_data_valid;
    logic          cfg_arb_mode;
    logic [LW-1:0] cfg_rd_latency;
    logic          arb_busy;

    glb_core_rd_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .st_rd_en         (st_rd_en),
        .st_rd_addr       (st_rd_addr),
        .st_rd_gnt        (st_rd_gnt),
        .pc_rd_en         (pc_rd_en),
        .pc_rd_addr       (pc_rd_addr),
        .pc_rd_gnt        (pc_rd_gnt),
        .bank_rd_en       (bank_rd_en),
        .bank_rd_addr     (bank_rd_addr),
        .bank_rd_data     (bank_rd_data),
        .st_rd_data       (st_rd_data),
        .st_rd_data_valid (st_rd_data_valid),
        .pc_rd_data       (pc_rd_data),
        .pc_rd_data_valid (pc_rd_data_valid),
        .cfg_arb_mode     (cfg_arb_mode),
        .cfg_rd_latency   (cfg_rd_latency),
        .arb_busy         (arb_busy)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] exp_q[$];
    int            lat_eff = 1;
    logic          prev_en = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    function automatic logic [DW-1:0] bank_word(input logic [AW-1:0] a);
        if (a == AW'(32'h40)) begin
            return DW'(64'h0000_0000_DEAD_BEEF);
        end
        return DW'(64'hA5A5_0000_0000_0000) ^ DW'(a);
    endfunction

    // ---------------- bank model: data valid lat_eff cycles after bank_rd_en ----------------
    logic [DW-1:0] slot_d [32];
    logic          slot_v [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            slot_v[i] = 1'b0;
            slot_d[i] = '0;
        end
        bank_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bank_rd_en === 1'b1) begin
                slot_d[(cyc + lat_eff) % 32] = bank_word(bank_rd_addr);
                slot_v[(cyc + lat_eff) % 32] = 1'b1;
            end
            if (slot_v[cyc % 32]) begin
                bank_rd_data        = slot_d[cyc % 32];
                slot_v[cyc % 32]    = 1'b0;
            end else begin
                bank_rd_data = DW'(64'hFFFF_0000_FFFF_0000);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [EW-1:0] mon_e;
    logic          mon_id;
    logic [DW-1:0] mon_data;

    initial begin
        forever begin
            @(negedge clk);
            if (st_rd_data_valid === 1'b1 || pc_rd_data_valid === 1'b1) begin
                checks++;
                if (st_rd_data_valid === 1'b1 && pc_rd_data_valid === 1'b1) begin
                    errors++;
                    $display("FAIL both_valid cyc %0d: st_valid=1 pc_valid=1, required at most one", cyc);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp cyc %0d: st_valid=%b pc_valid=%b, required none",
                             cyc, st_rd_data_valid, pc_rd_data_valid);
                end else begin
                    mon_e    = exp_q.pop_front();
                    mon_id   = pc_rd_data_valid;
                    mon_data = mon_id ? pc_rd_data : st_rd_data;
                    if (mon_id !== mon_e[EW-1] || mon_data !== mon_e[EW-2 -: DW] ||
                        cyc != int'(mon_e[31:0])) begin
                        errors++;
                        $display("FAIL resp: got pc=%b data=%h cyc=%0d, required pc=%b data=%h cyc=%0d",
                                 mon_id, mon_data, cyc, mon_e[EW-1], mon_e[EW-2 -: DW], int'(mon_e[31:0]));
                    end
                end
            end
            checks++;
            if ((st_rd_data_valid !== 1'b1 && st_rd_data !== '0) ||
                (pc_rd_data_valid !== 1'b1 && pc_rd_data !== '0)) begin
                errors++;
                $display("FAIL idle_data cyc %0d: st=%h pc=%h, required 0 when not valid",
                         cyc, st_rd_data, pc_rd_data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic se, input logic [AW-1:0] sa,
                        input logic pe, input logic [AW-1:0] pa,
                        input logic eg_st, input logic eg_pc);
        @(posedge clk);
        #1;
        st_rd_en   = se;
        st_rd_addr = sa;
        pc_rd_en   = pe;
        pc_rd_addr = pa;
        @(negedge clk);
        checks++;
        if (st_rd_gnt !== eg_st || pc_rd_gnt !== eg_pc) begin
            errors++;
            $display("FAIL gnt cyc %0d: st/pc got %b/%b, required %b/%b",
                     cyc, st_rd_gnt, pc_rd_gnt, eg_st, eg_pc);
        end
        checks++;
        if (bank_rd_en !== prev_en || bank_rd_addr !== prev_addr) begin
            errors++;
            $display("FAIL issue cyc %0d: en/addr got %b/%h, required %b/%h",
                     cyc, bank_rd_en, bank_rd_addr, prev_en, prev_addr);
        end
        if (eg_st) exp_q.push_back({1'b0, bank_word(sa), 32'(cyc + lat_eff + 1)});
        if (eg_pc) exp_q.push_back({1'b1, bank_word(pa), 32'(cyc + lat_eff + 1)});
        prev_en   = eg_st | eg_pc;
        prev_addr = eg_st ? sa : (eg_pc ? pa : '0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Only called after idle cycles, so nothing is in flight.
    task automatic set_cfg(input logic mode, input logic [LW-1:0] raw, input int eff);
        cfg_arb_mode   = mode;
        cfg_rd_latency = raw;
        lat_eff        = eff;
    endtask

    // ---------------- stimulus ----------------
    int g_cyc;

    initial begin
        reset_n        = 1'b0;
        st_rd_en       = 1'b1;
        st_rd_addr     = AW'(32'h100);
        pc_rd_en       = 1'b1;
        pc_rd_addr     = AW'(32'h200);
        cfg_arb_mode   = 1'b0;
        cfg_rd_latency = LW'(2);
        lat_eff        = 2;

        // reset state: requests present but no grant, outputs cleared
        repeat (2) @(negedge clk);
        checks++;
        if (st_rd_gnt !== 1'b0 || pc_rd_gnt !== 1'b0) begin
            errors++;
            $display("FAIL gnt_in_reset: st/pc got %b/%b, required 0/0", st_rd_gnt, pc_rd_gnt);
        end
        checks++;
        if (bank_rd_en !== 1'b0 || bank_rd_addr !== '0 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: en=%b addr=%h busy=%b, required 0/0/0",
                     bank_rd_en, bank_rd_addr, arb_busy);
        end
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        st_rd_en = 1'b0;
        pc_rd_en = 1'b0;

        // round-robin, L=2, both always requesting: ST first after reset
        set_cfg(1'b0, LW'(2), 2);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, AW'(32'h100), 1'b1, AW'(32'h200), (i % 2) == 0, (i % 2) == 1);
        end
        idle(12);

        // PC strict priority
        set_cfg(1'b1, LW'(2), 2);
        repeat (4) step(1'b1, AW'(32'h104), 1'b1, AW'(32'h204), 1'b0, 1'b1);
        step(1'b1, AW'(32'h108), 1'b0, AW'(32'h208), 1'b1, 1'b0);
        idle(12);

        // single PC read at L=5
        set_cfg(1'b1, LW'(5), 5);
        step(1'b0, '0, 1'b1, AW'(32'h40), 1'b0, 1'b1);
        idle(12);

        // latency clamp: 0 -> 1, 15 -> 8
        set_cfg(1'b0, LW'(0), 1);
        step(1'b1, AW'(32'h120), 1'b0, '0, 1'b1, 1'b0);
        idle(12);
        set_cfg(1'b0, LW'(15), 8);
        step(1'b0, '0, 1'b1, AW'(32'h220), 1'b0, 1'b1);
        idle(12);

        // round-robin pointer only moves on grants; single requesters always win
        set_cfg(1'b0, LW'(3), 3);
        step(1'b0, '0, 1'b1, AW'(32'h230), 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, AW'(32'h234), 1'b0, 1'b1);
        idle(1);
        step(1'b1, AW'(32'h130), 1'b1, AW'(32'h238), 1'b1, 1'b0);
        step(1'b1, AW'(32'h134), 1'b1, AW'(32'h23C), 1'b0, 1'b1);
        step(1'b1, AW'(32'h138), 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, AW'(32'h13C), 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, AW'(32'h140), 1'b1, AW'(32'h240), 1'b0, 1'b1);
        idle(12);

        // ST burst of 10 at L=3, then busy falls after the last response cycle
        for (int i = 0; i < 10; i++) begin
            step(1'b1, AW'(32'h300 + 4 * i), 1'b0, '0, 1'b1, 1'b0);
        end
        g_cyc = cyc;
        for (int i = 0; i < lat_eff + 3; i++) begin
            idle(1);
            checks++;
            if (arb_busy !== (cyc <= g_cyc + lat_eff + 1)) begin
                errors++;
                $display("FAIL busy_drop cyc %0d: got %b, required %b",
                         cyc, arb_busy, (cyc <= g_cyc + lat_eff + 1));
            end
        end
        idle(12);

        // reset in flight discards outstanding reads
        set_cfg(1'b1, LW'(4), 4);
        step(1'b0, '0, 1'b1, AW'(32'h500), 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, AW'(32'h504), 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, AW'(32'h508), 1'b0, 1'b1);
        @(posedge clk);
        #1;
        pc_rd_en = 1'b0;
        checks++;
        if (arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: got %b, required 1", arb_busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (arb_busy !== 1'b0 || bank_rd_en !== 1'b0 || bank_rd_addr !== '0 ||
            st_rd_data_valid !== 1'b0 || pc_rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b en=%b addr=%h stv=%b pcv=%b, required all 0",
                     arb_busy, bank_rd_en, bank_rd_addr, st_rd_data_valid, pc_rd_data_valid);
        end
        exp_q.delete();
        prev_en   = 1'b0;
        prev_addr = '0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle(12);

        // pointer returns to PC on reset, so ST wins first contention
        set_cfg(1'b0, LW'(2), 2);
        step(1'b1, AW'(32'h150), 1'b1, AW'(32'h250), 1'b1, 1'b0);
        step(1'b1, AW'(32'h154), 1'b1, AW'(32'h254), 1'b0, 1'b1);
        idle(12);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
